matrix_transpose_sched: RTL and testbench

Sequencing controller for the matrix transpose engine. It accepts a stream of elements over a valid/ready handshake and writes them row-major into the engine's NUM_MG×NUM_PE input array. It then triggers the transpose, waits for the engine's completion, and drains the result row-major onto an output stream. It repeats this for a programmed number of chunks, advancing the chunk address by CHUNK_SIZE each time.

---
 rtl/matrix_transpose_sched.sv | 210 +++++++++++++++++++++
 tb/tb_matrix_transpose_sched.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_transpose_sched.sv
// matrix_transpose_sched: sequencing controller for the matrix transpose engine.
// Loads one NUM_MG x NUM_PE chunk row-major from the input stream, triggers the
// engine, waits for completion and drains the result row-major. It repeats this
// for num_chunks chunks, stepping the chunk address by CHUNK_SIZE each time.
// Optional build macro: MT_SCHED_WATCHDOG_EN adds a WAIT-state watchdog that
// sets the sticky err flag and abandons the job after TIMEOUT_CYCLES cycles.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; job parameters captured on start
// LOAD  | accepting elements and writing them into the input array
// TRIG  | one-cycle engine trigger (eng_ctrl / eng_in_val)
// WAIT  | waiting for the engine completion pulse
// DRAIN | streaming the engine output array row-major
// NEXT  | chunk_done pulse; advance to next chunk or finish the job
module matrix_transpose_sched #(
    parameter int DATA_WIDTH     = 64,
    parameter int NUM_MG         = 64,
    parameter int NUM_PE         = NUM_MG,
    parameter int ADDR_WIDTH     = 64,
    parameter int CHUNK_SIZE     = 64,
    parameter int CNT_WIDTH      = 16,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int IW = $clog2(NUM_MG),
    localparam int JW = $clog2(NUM_PE)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [CNT_WIDTH-1:0]  num_chunks,
    output logic                  busy,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  load_we,
    output logic [IW-1:0]         load_sel_i,
    output logic [JW-1:0]         load_sel_j,
    output logic [DATA_WIDTH-1:0] load_data,
    output logic                  eng_ctrl,
    output logic                  eng_in_val,
    output logic [ADDR_WIDTH-1:0] eng_base_addr,
    output logic [ADDR_WIDTH-1:0] eng_chunk_addr,
    input  logic                  eng_out_val,
    output logic [IW-1:0]         rd_sel_i,
    output logic [JW-1:0]         rd_sel_j,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  chunk_done,
    output logic                  err
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_TRIG, S_WAIT, S_DRAIN, S_NEXT
    } state_t;

    state_t                state;
    logic [IW-1:0]         row_idx;
    logic [JW-1:0]         col_idx;
    logic [CNT_WIDTH-1:0]  chunk_idx;
    logic [CNT_WIDTH-1:0]  num_chunks_q;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [ADDR_WIDTH-1:0] chunk_addr_q;
    logic                  row_last;
    logic                  col_last;

    assign row_last = (row_idx == IW'(NUM_MG - 1));
    assign col_last = (col_idx == JW'(NUM_PE - 1));

    assign busy           = (state != S_IDLE);
    assign eng_in_val     = eng_ctrl;
    assign eng_base_addr  = base_q;
    // Running sum instead of chunk_idx*CHUNK_SIZE; identical modulo 2^ADDR_WIDTH.
    assign eng_chunk_addr = chunk_addr_q;
    // The read select is the live index, so it holds still while out_ready is low.
    assign rd_sel_i       = row_idx;
    assign rd_sel_j       = col_idx;
    assign out_data       = out_valid ? rd_data : '0;
    assign out_last       = out_valid & row_last & col_last;

`ifdef MT_SCHED_WATCHDOG_EN
    localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [WD_W-1:0] wd_cnt;
    logic            wd_expired;
    assign wd_expired = (wd_cnt == '0);
`else
    logic unused_timeout;
    assign unused_timeout = |TIMEOUT_CYCLES;
    assign err = 1'b0;
`endif

    // Sequencer FSM with registered strobes, indices and job context.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            row_idx      <= '0;
            col_idx      <= '0;
            chunk_idx    <= '0;
            num_chunks_q <= '0;
            base_q       <= '0;
            chunk_addr_q <= '0;
            in_ready     <= 1'b0;
            load_we      <= 1'b0;
            load_sel_i   <= '0;
            load_sel_j   <= '0;
            load_data    <= '0;
            eng_ctrl     <= 1'b0;
            out_valid    <= 1'b0;
            chunk_done   <= 1'b0;
`ifdef MT_SCHED_WATCHDOG_EN
            wd_cnt       <= '0;
            err          <= 1'b0;
`endif
        end else begin
            load_we    <= 1'b0;
            eng_ctrl   <= 1'b0;
            chunk_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        base_q       <= base_addr;
                        chunk_addr_q <= base_addr;
                        num_chunks_q <= (num_chunks == '0) ? CNT_WIDTH'(1) : num_chunks;
                        chunk_idx    <= '0;
                        row_idx      <= '0;
                        col_idx      <= '0;
                        in_ready     <= 1'b1;
                        state        <= S_LOAD;
`ifdef MT_SCHED_WATCHDOG_EN
                        err          <= 1'b0;
`endif
                    end
                end
                S_LOAD: begin
                    if (in_valid && in_ready) begin
                        load_we    <= 1'b1;
                        load_sel_i <= row_idx;
                        load_sel_j <= col_idx;
                        load_data  <= in_data;
                        if (row_last && col_last) begin
                            row_idx  <= '0;
                            col_idx  <= '0;
                            in_ready <= 1'b0;
                            state    <= S_TRIG;
                        end else if (col_last) begin
                            col_idx <= '0;
                            row_idx <= row_idx + IW'(1);
                        end else begin
                            col_idx <= col_idx + JW'(1);
                        end
                    end
                end
                S_TRIG: begin
                    eng_ctrl <= 1'b1;
                    state    <= S_WAIT;
`ifdef MT_SCHED_WATCHDOG_EN
                    wd_cnt   <= WD_W'(TIMEOUT_CYCLES - 1);
`endif
                end
                S_WAIT: begin
                    if (eng_out_val) begin
                        row_idx   <= '0;
                        col_idx   <= '0;
                        out_valid <= 1'b1;
                        state     <= S_DRAIN;
                    end
`ifdef MT_SCHED_WATCHDOG_EN
                    else if (wd_expired) begin
                        err   <= 1'b1;
                        state <= S_IDLE;
                    end else begin
                        wd_cnt <= wd_cnt - WD_W'(1);
                    end
`endif
                end
                S_DRAIN: begin
                    if (out_ready) begin
                        if (row_last && col_last) begin
                            out_valid  <= 1'b0;
                            chunk_done <= 1'b1;
                            state      <= S_NEXT;
                        end else if (col_last) begin
                            col_idx <= '0;
                            row_idx <= row_idx + IW'(1);
                        end else begin
                            col_idx <= col_idx + JW'(1);
                        end
                    end
                end
                S_NEXT: begin
                    chunk_idx <= chunk_idx + CNT_WIDTH'(1);
                    if (chunk_idx + CNT_WIDTH'(1) == num_chunks_q) begin
                        state <= S_IDLE;
                    end else begin
                        chunk_addr_q <= chunk_addr_q + ADDR_WIDTH'(CHUNK_SIZE);
                        row_idx      <= '0;
                        col_idx      <= '0;
                        in_ready     <= 1'b1;
                        state        <= S_LOAD;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_transpose_sched.sv
// Directed bench for matrix_transpose_sched with a 4x4 transposing engine model.
module tb_matrix_transpose_sched;

    localparam int DW = 16;
    localparam int MG = 4;
    localparam int PE = 4;
    localparam int AW = 32;
    localparam int CW = 16;
    localparam int CS = 64;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [CW-1:0] num_chunks;
    logic          busy;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          load_we;
    logic [1:0]    load_sel_i;
    logic [1:0]    load_sel_j;
    logic [DW-1:0] load_data;
    logic          eng_ctrl;
    logic          eng_in_val;
    logic [AW-1:0] eng_base_addr;
    logic [AW-1:0] eng_chunk_addr;
    logic          eng_out_val;
    logic [1:0]    rd_sel_i;
    logic [1:0]    rd_sel_j;
    logic [DW-1:0] rd_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          chunk_done;
    logic          err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] mem [MG][PE];
    int            ctrl_cnt = 0;
    int            done_cnt = 0;
    int            ldwe_cnt = 0;
    int            cd = 0;
    bit            eng_hold = 1'b0;
    logic [AW-1:0] addr_log [$];

    always #5 clk = ~clk;

    matrix_transpose_sched #(
        .DATA_WIDTH(DW), .NUM_MG(MG), .NUM_PE(PE), .ADDR_WIDTH(AW),
        .CHUNK_SIZE(CS), .CNT_WIDTH(CW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .num_chunks(num_chunks), .busy(busy), .in_valid(in_valid),
        .in_ready(in_ready), .in_data(in_data), .load_we(load_we),
        .load_sel_i(load_sel_i), .load_sel_j(load_sel_j), .load_data(load_data),
        .eng_ctrl(eng_ctrl), .eng_in_val(eng_in_val), .eng_base_addr(eng_base_addr),
        .eng_chunk_addr(eng_chunk_addr), .eng_out_val(eng_out_val),
        .rd_sel_i(rd_sel_i), .rd_sel_j(rd_sel_j), .rd_data(rd_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .chunk_done(chunk_done), .err(err)
    );

    // Engine output array is the transpose of its input array.
    assign rd_data = mem[rd_sel_j][rd_sel_i];

    // Engine model: captures load writes, replies eng_out_val 5 cycles after eng_ctrl.
    initial begin
        eng_out_val = 1'b0;
        for (int a = 0; a < MG; a++)
            for (int b = 0; b < PE; b++)
                mem[a][b] = '0;
        forever begin
            @(posedge clk);
            #2;
            if (!rst) begin
                cd = 0;
                eng_out_val = 1'b0;
            end else begin
                eng_out_val = 1'b0;
                if (cd > 0) begin
                    cd--;
                    if (cd == 0) eng_out_val = 1'b1;
                end
                if (eng_ctrl) begin
                    ctrl_cnt++;
                    addr_log.push_back(eng_chunk_addr);
                    if (!eng_hold) cd = 5;
                end
                if (chunk_done) done_cnt++;
                if (load_we) begin
                    ldwe_cnt++;
                    mem[load_sel_i][load_sel_j] = load_data;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: observed still running, expected finished");
        $fatal(1, "bench timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic start_job(input logic [AW-1:0] b, input logic [CW-1:0] n);
        base_addr  = b;
        num_chunks = n;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_busy", 64'(busy), 64'd1);
        check("start_in_ready", 64'(in_ready), 64'd1);
        check("base_capture", 64'(eng_base_addr), 64'(b));
        check("chunk_addr_first", 64'(eng_chunk_addr), 64'(b));
        check("start_err_clear", 64'(err), 64'd0);
    endtask

    task automatic feed(input logic [DW-1:0] v0, input int gap);
        int k = 0;
        int budget = 0;
        bit hs;
        while (k < 16 && budget < 2000) begin
            in_valid = (gap == 0) || ($urandom_range(0, 99) >= gap);
            in_data  = v0 + DW'(k);
            hs       = in_valid && in_ready;
            @(negedge clk);
            if (hs) k++;
            budget++;
        end
        in_valid = 1'b0;
        check("feed_count", 64'(k), 64'd16);
        check("in_ready_drop", 64'(in_ready), 64'd0);
        check("last_load_we", 64'(load_we), 64'd1);
        check("last_load_sel", 64'({load_sel_i, load_sel_j}), 64'hF);
        check("last_load_data", 64'(load_data), 64'(v0) + 64'd15);
        @(negedge clk);
        check("trig_eng_ctrl", 64'(eng_ctrl), 64'd1);
        check("trig_eng_in_val", 64'(eng_in_val), 64'd1);
        check("trig_no_load_we", 64'(load_we), 64'd0);
        @(negedge clk);
        check("eng_ctrl_one_cycle", 64'(eng_ctrl), 64'd0);
    endtask

    task automatic drain(input logic [DW-1:0] v0, input int gap, input int abort_at);
        int k = 0;
        int budget = 0;
        bit hs;
        bit stalled = 1'b0;
        bit eov_prev = 1'b0;
        logic [DW-1:0] held_d = '0;
        logic [3:0] held_sel = '0;
        while (k < 16 && budget < 2000) begin
            if (out_valid && k == abort_at) break;
            if (eov_prev) check("eov_to_out_valid", 64'(out_valid), 64'd1);
            eov_prev = eng_out_val;
            if (out_valid) begin
                if (stalled) begin
                    check("stall_out_data", 64'(out_data), 64'(held_d));
                    check("stall_rd_sel", 64'({rd_sel_i, rd_sel_j}), 64'(held_sel));
                end
                check("out_data", 64'(out_data), 64'(v0) + 64'(4 * (k % 4) + k / 4));
                check("out_last", 64'(out_last), 64'(k == 15));
            end
            out_ready = (gap == 0) || ($urandom_range(0, 99) >= gap);
            hs        = out_valid && out_ready;
            stalled   = out_valid && !out_ready;
            held_d    = out_data;
            held_sel  = {rd_sel_i, rd_sel_j};
            @(negedge clk);
            if (hs) k++;
            budget++;
        end
        out_ready = 1'b0;
        if (abort_at < 0) begin
            check("drain_count", 64'(k), 64'd16);
            check("chunk_done_pulse", 64'(chunk_done), 64'd1);
            check("out_valid_drop", 64'(out_valid), 64'd0);
        end
    endtask

    initial begin
        int c0;
        int d0;
        int w0;
        start      = 1'b0;
        base_addr  = '0;
        num_chunks = '0;
        in_valid   = 1'b0;
        in_data    = '0;
        out_ready  = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_load_we", 64'(load_we), 64'd0);
        check("rst_eng_ctrl", 64'(eng_ctrl), 64'd0);
        check("rst_chunk_done", 64'(chunk_done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_chunk_addr", 64'(eng_chunk_addr), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        rst = 1'b1;
        @(negedge clk);

        // Single chunk, no stalls
        c0 = ctrl_cnt; d0 = done_cnt; w0 = ldwe_cnt;
        start_job(32'h1000, 16'd1);
        feed(16'h0000, 0);
        drain(16'h0000, 0, -1);
        @(negedge clk);
        check("t1_busy_drop", 64'(busy), 64'd0);
        check("t1_chunk_done_one_cycle", 64'(chunk_done), 64'd0);
        check("t1_ctrl_pulses", 64'(ctrl_cnt - c0), 64'd1);
        check("t1_done_pulses", 64'(done_cnt - d0), 64'd1);
        check("t1_load_writes", 64'(ldwe_cnt - w0), 64'd16);

        // Random stalls on both streams
        c0 = ctrl_cnt;
        start_job(32'h2000, 16'd1);
        feed(16'h0100, 50);
        drain(16'h0100, 50, -1);
        @(negedge clk);
        check("t2_busy_drop", 64'(busy), 64'd0);
        check("t2_ctrl_pulses", 64'(ctrl_cnt - c0), 64'd1);

        // Three chunks, address stride
        c0 = ctrl_cnt; d0 = done_cnt;
        start_job(32'h1000, 16'd3);
        for (int c = 0; c < 3; c++) begin
            check("t3_chunk_addr", 64'(eng_chunk_addr), 64'(32'h1000 + c * CS));
            feed(DW'(16'h0200 + c * 32), 0);
            drain(DW'(16'h0200 + c * 32), 0, -1);
            @(negedge clk);
            if (c < 2) check("t3_turnaround_in_ready", 64'(in_ready), 64'd1);
        end
        check("t3_busy_drop", 64'(busy), 64'd0);
        check("t3_ctrl_pulses", 64'(ctrl_cnt - c0), 64'd3);
        check("t3_done_pulses", 64'(done_cnt - d0), 64'd3);
        check("t3_addr0", 64'(addr_log[c0]), 64'h1000);
        check("t3_addr1", 64'(addr_log[c0 + 1]), 64'h1040);
        check("t3_addr2", 64'(addr_log[c0 + 2]), 64'h1080);

        // num_chunks=0 runs one chunk; start during LOAD ignored
        c0 = ctrl_cnt; d0 = done_cnt;
        start_job(32'h3000, 16'd0);
        base_addr  = 32'hDEAD0000;
        num_chunks = 16'd5;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("t4_start_ignored_base", 64'(eng_base_addr), 64'h3000);
        check("t4_still_loading", 64'(in_ready), 64'd1);
        feed(16'h0300, 0);
        drain(16'h0300, 0, -1);
        @(negedge clk);
        check("t4_busy_drop", 64'(busy), 64'd0);
        check("t4_ctrl_pulses", 64'(ctrl_cnt - c0), 64'd1);
        check("t4_done_pulses", 64'(done_cnt - d0), 64'd1);

        // Reset during DRAIN at the 7th element
        start_job(32'h4000, 16'd1);
        feed(16'h0400, 0);
        drain(16'h0400, 0, 6);
        check("t5_mid_drain", 64'(out_valid), 64'd1);
        check("t5_mid_drain_data", 64'(out_data), 64'h0409);
        rst = 1'b0;
        #1;
        check("t5_busy", 64'(busy), 64'd0);
        check("t5_out_valid", 64'(out_valid), 64'd0);
        check("t5_out_data", 64'(out_data), 64'd0);
        check("t5_out_last", 64'(out_last), 64'd0);
        check("t5_in_ready", 64'(in_ready), 64'd0);
        check("t5_load_we", 64'(load_we), 64'd0);
        check("t5_eng_ctrl", 64'(eng_ctrl), 64'd0);
        check("t5_base_addr", 64'(eng_base_addr), 64'd0);
        c0 = ctrl_cnt; w0 = ldwe_cnt;
        repeat (3) @(negedge clk);
        check("t5_no_ctrl", 64'(ctrl_cnt - c0), 64'd0);
        check("t5_no_load_we", 64'(ldwe_cnt - w0), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        start_job(32'h5000, 16'd1);
        feed(16'h0500, 0);
        drain(16'h0500, 0, -1);
        @(negedge clk);
        check("t5_rerun_busy_drop", 64'(busy), 64'd0);

`ifdef MT_SCHED_WATCHDOG_EN
        // Watchdog: engine never completes
        eng_hold = 1'b1;
        start_job(32'h6000, 16'd1);
        feed(16'h0600, 0);
        repeat (6) @(negedge clk);
        check("wd_busy_at_limit", 64'(busy), 64'd1);
        check("wd_err_before_limit", 64'(err), 64'd0);
        @(negedge clk);
        check("wd_back_to_idle", 64'(busy), 64'd0);
        check("wd_err_set", 64'(err), 64'd1);
        check("wd_no_out_valid", 64'(out_valid), 64'd0);
        eng_hold = 1'b0;
        @(negedge clk);
        check("wd_err_sticky", 64'(err), 64'd1);
        start_job(32'h7000, 16'd1);
        feed(16'h0700, 0);
        drain(16'h0700, 0, -1);
        @(negedge clk);
        check("wd_rerun_busy_drop", 64'(busy), 64'd0);
        check("wd_rerun_err", 64'(err), 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
